// File: rtl/timer_bank.sv
// timer_bank: N_CH independent programmable pulse timers sharing one slow-rate prescaler.
// pulse/busy are registered one edge after the counting decision; no backpressure, period writes always land.
module timer_bank #(
   parameter int N_CH           = 6,
   parameter int CNT_W          = 27,
   parameter int DEFAULT_PERIOD = 100_000_000,
   parameter int SLOW_DIV       = 25
) (
   input  logic                                      clk100MHz,
   input  logic                                      rst,
   input  logic [N_CH-1:0]                           ch_en,
   input  logic [N_CH-1:0]                           ch_oneshot,
   input  logic [N_CH-1:0]                           ch_slow,
   input  logic                                      cfg_we,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
   input  logic [CNT_W-1:0]                          cfg_period,
   output logic [N_CH-1:0]                           pulse,
   output logic [N_CH-1:0]                           busy
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PS_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(SLOW_DIV - 1);
   localparam logic [CNT_W-1:0] PER_RST = CNT_W'(DEFAULT_PERIOD);

   logic [PS_W-1:0]  ps_q, ps_d;
   logic             slow_tick;
   logic [N_CH-1:0]  ce;
   logic [CNT_W-1:0] period_q [N_CH];
   logic [CNT_W-1:0] period_d [N_CH];
   logic [CNT_W-1:0] cnt_q    [N_CH];
   logic [CNT_W-1:0] cnt_d    [N_CH];
   logic [N_CH-1:0]  done_q, done_d;
   logic [N_CH-1:0]  pulse_q, pulse_d;
   logic [N_CH-1:0]  busy_q, busy_d;

   assign slow_tick = (ps_q == PS_LAST);
   assign ps_d      = slow_tick ? '0 : ps_q + PS_W'(1);
   assign ce        = ~ch_slow | {N_CH{slow_tick}};

   always_comb begin
      period_d = period_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      pulse_d  = '0;
      busy_d   = '0;
      for (int i = 0; i < N_CH; i++) begin
         // busy ignores a coincident period write: it reflects the running state only
         busy_d[i] = ch_en[i] && !done_q[i] && (period_q[i] != '0);
         if (cfg_we && (cfg_ch == CH_W'(i))) begin
            period_d[i] = cfg_period;
            cnt_d[i]    = '0;
         end else if (!ch_en[i]) begin
            cnt_d[i]  = '0;
            done_d[i] = 1'b0;
         end else if (done_q[i]) begin
            cnt_d[i]  = '0;
            done_d[i] = ch_oneshot[i];
         end else if (period_q[i] == '0) begin
            cnt_d[i] = '0;
         end else if (ce[i]) begin
            if (cnt_q[i] == period_q[i] - CNT_W'(1)) begin
               cnt_d[i]   = '0;
               pulse_d[i] = 1'b1;
               done_d[i]  = ch_oneshot[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk100MHz or posedge rst) begin
      if (rst) begin
         ps_q    <= '0;
         done_q  <= '0;
         pulse_q <= '0;
         busy_q  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            period_q[i] <= PER_RST;
            cnt_q[i]    <= '0;
         end
      end else begin
         ps_q     <= ps_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         pulse_q  <= pulse_d;
         busy_q   <= busy_d;
      end
   end

   assign pulse = pulse_q;
   assign busy  = busy_q;
endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised bank of N_CH independent pulse timers, replacing fixed-period, fixed-count timer clusters.
- Each channel has a runtime-programmable period, a per-channel enable, periodic or one-shot mode, and fast or slow count rate.
- The slow rate comes from an internal shared prescaler, so a second clock domain is not needed.
- Sits beside game/entity logic and provides movement and speed strobes on the 100 MHz system clock.

Parameters:
- N_CH, 6, number of timer channels (>=1).
- CNT_W, 27, width of the period register and counter per channel.
- DEFAULT_PERIOD, 100_000_000, period loaded into every channel on reset; must fit in CNT_W.
- SLOW_DIV, 25, prescaler divide ratio for slow-mode channels (>=1).

Ports:
- clk100MHz, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- ch_en, input, N_CH, per-channel run enable.
- ch_oneshot, input, N_CH, 1 = one-shot mode, 0 = periodic mode.
- ch_slow, input, N_CH, 1 = count on slow_tick, 0 = count every cycle.
- cfg_we, input, 1, period write strobe.
- cfg_ch, input, max(1,$clog2(N_CH)), channel index for the write.
- cfg_period, input, CNT_W, new period value.
- pulse, output, N_CH, one-cycle terminal-count strobes (registered).
- busy, output, N_CH, channel is actively counting (registered).

Behaviour:
- Reset (asynchronous, rst=1):
  - all counters = 0, pulse = 0, busy = 0, done flags = 0, prescaler = 0.
  - every period register = DEFAULT_PERIOD.
- Prescaler:
  - free-running count 0..SLOW_DIV-1, wraps to 0.
  - slow_tick is high combinationally while prescaler == SLOW_DIV-1, i.e. once every SLOW_DIV cycles.
  - SLOW_DIV = 1 makes slow_tick constantly 1.
- Per-channel count enable: ce = ch_slow ? slow_tick : 1.
- Per-channel state, evaluated each rising edge in priority order:
  1. cfg_we=1 and cfg_ch==this channel: period <= cfg_period; counter <= 0; pulse <= 0; done unchanged.
  2. ch_en=0: counter <= 0; pulse <= 0; done <= 0; busy <= 0.
  3. done=1 (one-shot fired): counter held at 0; pulse <= 0; busy <= 0.
  4. period == 0: channel halted; counter held at 0; pulse <= 0; busy <= 0.
  5. Otherwise busy <= 1:
     - If ce and counter == period-1: counter <= 0, pulse <= 1, and done <= ch_oneshot.
     - Else if ce: counter <= counter+1, pulse <= 0.
     - Else: hold counter, pulse <= 0.
- busy updates on the same edge as counter/pulse. During a rule-1 write cycle, busy follows rules 2-5 as if the write were absent.
- Latency:
  - Fast mode, period P >= 1: the first pulse is high in the cycle after the P-th edge at which ch_en is sampled 1 (counting from the edge after enable or after a period write).
  - Subsequent pulses follow every P cycles.
  - P = 1 in fast mode gives pulse continuously high.
- Slow mode: the counter advances only on slow_tick edges, giving a pulse period of P*SLOW_DIV cycles. Pulse width is still exactly one clk100MHz cycle.
- Toggling ch_slow mid-count: the counter keeps its value; no restart.
- One-shot:
  - After the terminal pulse, the channel idles until ch_en goes low.
  - Re-asserting ch_en starts a fresh count.
  - Clearing ch_oneshot while done=1 also clears done; the channel then resumes periodic counting from 0.
- Simultaneous events:
  - A write to a channel that is at terminal count wins: no pulse, counter 0.
  - Writes to other channels are unaffected.
- cfg_ch >= N_CH: the write is ignored.
- Reset mid-count: immediate return to reset values, including periods (reprogramming is required afterwards).
- Channels are fully independent; there is no shared state except the prescaler.

Test Plan:
- Setup: N_CH=3, CNT_W=8, DEFAULT_PERIOD=10, SLOW_DIV=4.
- Fast periodic:
  - Stimulus: release rst, ch_en=3'b001.
  - Required: pulse[0] high for 1 cycle after the 10th enabled edge, then every 10 cycles; busy[0]=1; pulse[2:1]=0, busy[2:1]=0.
- Slow mode:
  - Stimulus: ch_en[1]=1, ch_slow[1]=1, default period.
  - Required: pulse[1] period = 40 cycles, each pulse exactly 1 cycle wide.
- Reprogram mid-count:
  - Stimulus: channel 0 counter at 5; write cfg_ch=0, cfg_period=3.
  - Required: counter resets to 0; next pulse[0] 3 cycles after the write edge, then every 3 cycles.
  - Also: cfg_ch=3 writes are ignored.
- One-shot:
  - Stimulus: ch_oneshot[2]=1, ch_en[2]=1, period 4.
  - Required: a single pulse[2] after 4 cycles, busy[2] drops to 0, no further pulses for 50 cycles.
  - Then: toggle ch_en[2] 0→1 → another single pulse 4 cycles later.
- Boundaries:
  - period 0 → no pulses, busy=0.
  - period 1 fast → pulse stays high.
  - Write coincident with terminal count → no pulse that cycle.
- Reset:
  - Stimulus: assert rst asynchronously mid-count (between edges).
  - Required: pulse and busy go 0 immediately; after release, periods are back to 10 and counting restarts from 0.
